// File: rtl/grid_window_gen.sv
// Raster-order 3x3 neighbourhood generator: two line buffers feed a 3x3 shift
// window, and a grid is emitted only when the whole window lies inside the frame.
module grid_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  iPixel,
  input  logic        iPixelValid,
  input  logic        iFrameStart,
  output logic [71:0] oGrid,
  output logic        oGridValid,
  output logic [15:0] oCenterX,
  output logic [15:0] oCenterY,
  output logic        oFrameDone
);

  localparam int          AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  // lb0 holds line y-2, lb1 holds line y-1 at the current column
  logic [7:0] lb0_mem [0:IMG_WIDTH-1];
  logic [7:0] lb1_mem [0:IMG_WIDTH-1];

  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [15:0]   pos_x, pos_y;
  logic [AW-1:0] addr;
  logic [7:0]    top_in, mid_in;
  logic [71:0]   win_q, win_d;
  logic [71:0]   grid_q, grid_d;
  logic          grid_valid_q, grid_valid_d;
  logic [15:0]   center_x_q, center_x_d;
  logic [15:0]   center_y_q, center_y_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    pos_x  = iFrameStart ? 16'd0 : x_q;
    pos_y  = iFrameStart ? 16'd0 : y_q;
    addr   = pos_x[AW-1:0];
    top_in = lb0_mem[addr];
    mid_in = lb1_mem[addr];

    x_d          = x_q;
    y_d          = y_q;
    win_d        = win_q;
    grid_d       = grid_q;
    grid_valid_d = 1'b0;
    center_x_d   = center_x_q;
    center_y_d   = center_y_q;
    frame_done_d = 1'b0;

    if (iPixelValid) begin
      // byte 3r+c: c=0 newest column, so each row shifts towards higher c
      for (int r = 0; r < 3; r++) begin
        win_d[24*r+16 +: 8] = win_q[24*r+8 +: 8];
        win_d[24*r+8  +: 8] = win_q[24*r   +: 8];
      end
      win_d[7:0]   = top_in;
      win_d[31:24] = mid_in;
      win_d[55:48] = iPixel;

      if (pos_x == X_LAST) begin
        x_d = 16'd0;
        if (pos_y == Y_LAST) begin
          y_d          = 16'd0;
          frame_done_d = 1'b1;
        end else begin
          y_d = pos_y + 16'd1;
        end
      end else begin
        x_d = pos_x + 16'd1;
        y_d = pos_y;
      end

      if (pos_x >= 16'd2 && pos_y >= 16'd2) begin
        grid_valid_d = 1'b1;
        grid_d       = win_d;
        center_x_d   = pos_x - 16'd1;
        center_y_d   = pos_y - 16'd1;
      end
    end
  end

  // Line buffer contents are left unreset; stale data never reaches a valid grid.
  always_ff @(posedge clk) begin
    if (iPixelValid) begin
      lb0_mem[addr] <= mid_in;
      lb1_mem[addr] <= iPixel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q          <= '0;
      y_q          <= '0;
      win_q        <= '0;
      grid_q       <= '0;
      grid_valid_q <= 1'b0;
      center_x_q   <= '0;
      center_y_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_q        <= win_d;
      grid_q       <= grid_d;
      grid_valid_q <= grid_valid_d;
      center_x_q   <= center_x_d;
      center_y_q   <= center_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oGrid      = grid_q;
  assign oGridValid = grid_valid_q;
  assign oCenterX   = center_x_q;
  assign oCenterY   = center_y_q;
  assign oFrameDone = frame_done_q;

endmodule
